// File: rtl/fsm_control_pkg.sv
// Shared game sequencing types: the top-level phase encoding, reused by
// debug and status logic that needs to decode the sequencer state.
package fsm_control_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'b00,
        RUN    = 2'b01,
        UPDATE = 2'b10,
        OVER   = 2'b11
    } state_t;

endpackage : fsm_control_pkg

// File: rtl/fsm_control.sv
// Top-level game sequencer: initial draw, steady game loop, display update
// after a change and game-over hold, with one-hot Moore phase enables.
module fsm_control
    import fsm_control_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic GameOver,
    input  logic cmd_done,
    input  logic diff,
    input  logic mode_pb,
    output logic enable_loop,
    output logic init_cycle,
    output logic en_update,
    output logic sync_reset
);

    state_t state_q;
    state_t state_d;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; the async reset lands in INIT without a clock.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    if (cmd_done) state_d = RUN;
            RUN: begin
                // End of game outranks a pending display update.
                if (GameOver)  state_d = OVER;
                else if (diff) state_d = UPDATE;
            end
            UPDATE:  if (cmd_done) state_d = RUN;
            OVER:    if (mode_pb)  state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Outputs decode the register only, so no input reaches them combinationally.
    always_comb begin
        init_cycle  = 1'b0;
        enable_loop = 1'b0;
        en_update   = 1'b0;
        sync_reset  = 1'b0;
        unique case (state_q)
            INIT:    init_cycle  = 1'b1;
            RUN:     enable_loop = 1'b1;
            UPDATE:  en_update   = 1'b1;
            OVER:    sync_reset  = 1'b1;
            default: init_cycle  = 1'b1;
        endcase
    end

endmodule : fsm_control

// File: tb/tb_fsm_control.sv
// Scoreboard bench for fsm_control: stimulus queues the expected phase
// vector per edge, a monitor pops and compares after each rising edge.
module tb_fsm_control;

    // Output vector order: {init_cycle, enable_loop, en_update, sync_reset}
    localparam logic [3:0] O_INIT = 4'b1000;
    localparam logic [3:0] O_RUN  = 4'b0100;
    localparam logic [3:0] O_UPD  = 4'b0010;
    localparam logic [3:0] O_OVER = 4'b0001;

    typedef struct {
        logic [3:0] outs;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic nrst;
    logic GameOver, cmd_done, diff, mode_pb;
    logic enable_loop, init_cycle, en_update, sync_reset;
    logic [3:0] outs;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    assign outs = {init_cycle, enable_loop, en_update, sync_reset};

    fsm_control dut (
        .clk         (clk),
        .nrst        (nrst),
        .GameOver    (GameOver),
        .cmd_done    (cmd_done),
        .diff        (diff),
        .mode_pb     (mode_pb),
        .enable_loop (enable_loop),
        .init_cycle  (init_cycle),
        .en_update   (en_update),
        .sync_reset  (sync_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and queue the outputs
    // expected right after the following rising edge.
    task automatic step(input logic go, input logic cd, input logic df, input logic pb,
                        input logic [3:0] exp_outs, input string nm);
        @(negedge clk);
        GameOver = go;
        cmd_done = cd;
        diff     = df;
        mode_pb  = pb;
        exp_q.push_back('{exp_outs, nm});
        @(posedge clk);
    endtask

    task automatic async_reset(input string nm);
        @(negedge clk);
        {GameOver, cmd_done, diff, mode_pb} = 4'b0000;
        #2 nrst = 1'b0;
        #1 check({nm, "_async"}, 32'(outs), 32'(O_INIT));
        @(negedge clk);
        nrst = 1'b1;
    endtask

    // Monitor: one-hot on every edge, plus scoreboard compare when queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("one_hot", 32'($onehot(outs)), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.name, 32'(outs), 32'(e.outs));
            end
        end
    end

    initial begin
        nrst = 1'b0;
        {GameOver, cmd_done, diff, mode_pb} = 4'b0000;
        #1 check("reset_outputs", 32'(outs), 32'(O_INIT));
        repeat (2) @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;

        for (int i = 0; i < 50; i++) step(0, 0, 0, 0, O_INIT, "init_hold");

        step(0, 0, 0, 1, O_INIT, "init_ignore_mode_pb");
        step(0, 0, 1, 0, O_INIT, "init_ignore_diff");
        step(1, 0, 0, 0, O_INIT, "init_ignore_gameover");

        step(0, 1, 0, 0, O_RUN,  "init_to_run");
        step(0, 1, 0, 0, O_RUN,  "run_held_cmd_done");
        step(0, 0, 1, 0, O_UPD,  "run_to_update");
        step(1, 0, 0, 0, O_UPD,  "update_ignore_gameover");
        step(1, 0, 1, 0, O_UPD,  "update_ignore_go_diff");
        step(0, 0, 0, 1, O_UPD,  "update_ignore_mode_pb");
        step(0, 1, 0, 0, O_RUN,  "update_to_run");

        step(0, 0, 1, 0, O_UPD,  "diff_enter_update");
        step(0, 1, 1, 0, O_RUN,  "return_with_diff_held");
        step(0, 0, 1, 0, O_UPD,  "held_diff_reenters");
        step(0, 1, 0, 0, O_RUN,  "update_to_run_2");
        step(0, 0, 0, 1, O_RUN,  "run_ignore_mode_pb");

        step(1, 0, 0, 0, O_OVER, "run_to_over");
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, O_OVER, "over_dwell");
        step(0, 1, 1, 0, O_OVER, "over_ignore_cd_diff");
        step(0, 0, 0, 1, O_RUN,  "mode_pb_pulse_to_run");

        step(1, 0, 1, 0, O_OVER, "gameover_beats_diff");
        step(0, 0, 0, 1, O_RUN,  "over_to_run");

        step(1, 0, 0, 0, O_OVER, "enter_over_for_reset");
        async_reset("over");
        step(0, 0, 0, 0, O_INIT, "after_reset_over_waits");
        step(0, 1, 0, 0, O_RUN,  "after_reset_to_run");
        step(0, 0, 1, 0, O_UPD,  "enter_update_for_reset");
        async_reset("update");
        step(0, 0, 0, 0, O_INIT, "after_reset_update_waits");

        // Random run: only the monitor's one-hot check applies here.
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            {GameOver, cmd_done, diff, mode_pb} = 4'($urandom_range(0, 15));
        end

        repeat (3) @(posedge clk);
        #2 check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fsm_control
